// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready payload channel between two pipeline stages.
// The producer takes the master modport, the consumer the slave.
interface pipe_stage_elastic_if #(
   parameter int WIDTH = 160
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: 2-entry skid buffer with flush,
// sticky halt flag and a saturating flush-drop counter.
module pipe_stage_elastic #(
   parameter int               WIDTH     = 160,
   parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
   parameter int               HALT_BIT  = 0,
   parameter int               DROP_W    = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   pipe_stage_elastic_if.slave  up,
   pipe_stage_elastic_if.master dn,
   input  logic                 stall,
   input  logic                 flush,
   output logic [1:0]           occupancy,
   output logic                 halt,
   output logic [DROP_W-1:0]    drop_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [DROP_W+1:0] DROP_MAX =
      {2'b00, {DROP_W{1'b1}}};

   state_t            state_q;
   logic [WIDTH-1:0]  main_q;
   logic [WIDTH-1:0]  skid_q;
   logic              halt_q;
   logic [DROP_W-1:0] drop_q;
   logic              in_fire;
   logic              out_fire;
   logic [DROP_W+1:0] drop_sum;

   // in_ready depends only on registered state and local controls,
   // never on out_ready, so no combinational path crosses the stage.
   assign up.ready = !RST && !flush && !stall && (state_q != FULL);
   assign dn.valid = (state_q != EMPTY) && !flush && !stall;
   assign dn.data  = main_q;

   assign in_fire  = up.valid && up.ready;
   assign out_fire = dn.valid && dn.ready;

   assign occupancy = state_q;
   assign halt      = halt_q;
   assign drop_cnt  = drop_q;

   assign drop_sum = {2'b00, drop_q} + {{DROP_W{1'b0}}, occupancy};

   // Buffer state, flush handling, halt capture and drop counting.
   // Stall needs no branch: it masks both fires, so everything holds.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= EMPTY;
         main_q  <= FLUSH_VAL;
         skid_q  <= FLUSH_VAL;
         halt_q  <= 1'b0;
         drop_q  <= '0;
      end else if (flush) begin
         state_q <= EMPTY;
         main_q  <= FLUSH_VAL;
         skid_q  <= FLUSH_VAL;
         if (drop_sum > DROP_MAX) drop_q <= '1;
         else                     drop_q <= drop_sum[DROP_W-1:0];
      end else begin
         if (out_fire && main_q[HALT_BIT]) halt_q <= 1'b1;
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_q  <= up.data;
                  state_q <= ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= up.data;
               end else if (in_fire) begin
                  skid_q  <= up.data;
                  state_q <= FULL;
               end else if (out_fire) begin
                  state_q <= EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_q  <= skid_q;
                  skid_q  <= FLUSH_VAL;
                  state_q <= ONE;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

endmodule
